// File: rtl/pmod_als_pkg.sv
// Shared definitions for the light-sensor display path: the converter FSM states,
// the ASCII code points it emits and the double-dabble iteration count.
package pmod_als_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADJUST = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [3:0] BCD_ITER    = 4'd8;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One double-dabble correction cell: a BCD nibble of 5 or more gets 3 added so
// that the following left shift carries correctly into the next decade.
module bcd_digit_adjust (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/conversor_bcd_ascii.sv
// Iterative binary-to-BCD converter (double dabble) with ASCII digit outputs for the UART mux.
// Define LEADING_BLANK_EN to replace leading zero digits with spaces on ascii_c/ascii_d.
module conversor_bcd_ascii
  import pmod_als_pkg::*;
#(
  parameter int IN_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] bin_in,
  output logic            busy,
  output logic            done,
  output logic [11:0]     bcd_out,
  output logic [7:0]      ascii_c,
  output logic [7:0]      ascii_d,
  output logic [7:0]      ascii_u
);

  generate
    if (IN_W != 8) begin : g_bad_width
      $fatal(1, "conversor_bcd_ascii: IN_W must be 8");
    end
  endgenerate

`ifdef LEADING_BLANK_EN
  localparam logic [7:0] ASCII_LEAD_RST = ASCII_SPACE;
`else
  localparam logic [7:0] ASCII_LEAD_RST = ASCII_ZERO;
`endif

  state_t      state, state_nx;
  logic [19:0] scratch, scratch_nx;
  logic [3:0]  iter_cnt, iter_cnt_nx;
  logic        load_result;

  logic [3:0]  adj_h, adj_t, adj_u;
  logic [19:0] adjusted, shifted;
  logic [11:0] res_bcd;
  logic [7:0]  asc_c_nx, asc_d_nx, asc_u_nx;

  bcd_digit_adjust u_adj_h (.digit_in(scratch[19:16]), .digit_out(adj_h));
  bcd_digit_adjust u_adj_t (.digit_in(scratch[15:12]), .digit_out(adj_t));
  bcd_digit_adjust u_adj_u (.digit_in(scratch[11:8]),  .digit_out(adj_u));

  assign adjusted = {adj_h, adj_t, adj_u, scratch[7:0]};
  assign shifted  = {scratch[18:0], 1'b0};
  assign res_bcd  = shifted[19:8];

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    state_nx    = state;
    scratch_nx  = scratch;
    iter_cnt_nx = iter_cnt;
    load_result = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          scratch_nx  = {12'h000, bin_in};
          iter_cnt_nx = BCD_ITER;
          state_nx    = ADJUST;
        end
      end
      ADJUST: begin
        scratch_nx = adjusted;
        state_nx   = SHIFT;
      end
      SHIFT: begin
        scratch_nx  = shifted;
        iter_cnt_nx = iter_cnt - 4'd1;
        if (iter_cnt == 4'd1) begin
          state_nx    = DONE;
          load_result = 1'b1;
        end else begin
          state_nx = ADJUST;
        end
      end
      DONE: begin
        // DONE already behaves as idle towards the requester, so a start here chains directly.
        if (start) begin
          scratch_nx  = {12'h000, bin_in};
          iter_cnt_nx = BCD_ITER;
          state_nx    = ADJUST;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    asc_c_nx = ASCII_ZERO + {4'h0, res_bcd[11:8]};
    asc_d_nx = ASCII_ZERO + {4'h0, res_bcd[7:4]};
    asc_u_nx = ASCII_ZERO + {4'h0, res_bcd[3:0]};
`ifdef LEADING_BLANK_EN
    if (res_bcd[11:8] == 4'd0) asc_c_nx = ASCII_SPACE;
    if (res_bcd[11:4] == 8'd0) asc_d_nx = ASCII_SPACE;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      scratch  <= 20'h00000;
      iter_cnt <= 4'd0;
    end else begin
      state    <= state_nx;
      scratch  <= scratch_nx;
      iter_cnt <= iter_cnt_nx;
    end
  end

  // Results are captured on the edge that enters DONE, so they are already valid while done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_out <= 12'h000;
      ascii_c <= ASCII_LEAD_RST;
      ascii_d <= ASCII_LEAD_RST;
      ascii_u <= ASCII_ZERO;
    end else if (load_result) begin
      bcd_out <= res_bcd;
      ascii_c <= asc_c_nx;
      ascii_d <= asc_d_nx;
      ascii_u <= asc_u_nx;
    end
  end

  assign busy = (state == ADJUST) || (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_conversor_bcd_ascii.sv
// Self-checking bench for conversor_bcd_ascii: directed corner cases plus random
// conversions compared against a decimal-arithmetic reference model.
module tb_conversor_bcd_ascii;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
  logic [7:0]  ascii_c, ascii_d, ascii_u;

  int checks   = 0;
  int failures = 0;

  logic [11:0] prev_bcd;
  logic [23:0] prev_asc;

  conversor_bcd_ascii #(.IN_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ascii_c (ascii_c),
    .ascii_d (ascii_d),
    .ascii_u (ascii_u)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  function automatic logic [23:0] model_ascii(input int v);
    logic [7:0] c, d, u;
    c = 8'(8'h30 + v / 100);
    d = 8'(8'h30 + (v / 10) % 10);
    u = 8'(8'h30 + v % 10);
`ifdef LEADING_BLANK_EN
    if (v / 100 == 0) c = 8'h20;
    if (v / 10 == 0)  d = 8'h20;
`endif
    return {c, d, u};
  endfunction

  // Starts a conversion of v (start sampled at the next edge, edge 0) and checks
  // every cycle 1..17. inj_cycle>0 raises start with inj_val during that cycle.
  // Returns at the falling edge inside cycle 17.
  task automatic convert(input int v, input int inj_cycle, input int inj_val, input string tag);
    int dones = 0;
    start  = 1'b1;
    bin_in = 8'(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      if (n == inj_cycle) begin
        start  = 1'b1;
        bin_in = 8'(inj_val);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      check({tag, "_busy"}, 32'(busy), 32'(n <= 16));
      check({tag, "_done"}, 32'(done), 32'(n == 17));
      if (done) dones++;
      if (n == 8) begin
        check({tag, "_hold_bcd"}, 32'(bcd_out), 32'(prev_bcd));
        check({tag, "_hold_ascii"}, 32'({ascii_c, ascii_d, ascii_u}), 32'(prev_asc));
      end
      if (n < 17) begin
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    check({tag, "_bcd"}, 32'(bcd_out), 32'(model_bcd(v)));
    check({tag, "_ascii"}, 32'({ascii_c, ascii_d, ascii_u}), 32'(model_ascii(v)));
    check({tag, "_ndone"}, 32'(dones), 32'd1);
    prev_bcd = model_bcd(v);
    prev_asc = model_ascii(v);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_bcd"}, 32'(bcd_out), 32'h000);
    check({tag, "_ascii"}, 32'({ascii_c, ascii_d, ascii_u}), 32'(model_ascii(0)));
  endtask

  initial begin
    int saw_done;
    rst      = 1'b1;
    start    = 1'b0;
    bin_in   = 8'h00;
    prev_bcd = 12'h000;
    prev_asc = model_ascii(0);

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);

    // Directed corner values.
    convert(255, 0, 0, "v255");
    check("v255_lit_bcd", 32'(bcd_out), 32'h255);
    check("v255_lit_ascii", 32'({ascii_c, ascii_d, ascii_u}), 32'h323535);
    repeat (2) @(negedge clk);
    convert(0, 0, 0, "v0");
    repeat (1) @(negedge clk);
    convert(7, 0, 0, "v7");
    repeat (1) @(negedge clk);
    convert(40, 0, 0, "v40");
    repeat (1) @(negedge clk);
    convert(100, 0, 0, "v100");
    check("v100_lit_ascii", 32'({ascii_c, ascii_d, ascii_u}), 32'h313030);
    repeat (1) @(negedge clk);

    // Start while busy must be ignored.
    convert(200, 5, 99, "ign200");
    check("ign200_lit_bcd", 32'(bcd_out), 32'h200);
    repeat (1) @(negedge clk);

    // Back-to-back: the second start is raised in the done cycle of the first.
    convert(17, 0, 0, "b2b_first");
    convert(42, 0, 0, "b2b_42");
    check("b2b_lit_bcd", 32'(bcd_out), 32'h042);
    repeat (2) @(negedge clk);

    // Reset in cycle 8 of a conversion of 123.
    start  = 1'b1;
    bin_in = 8'd123;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    prev_bcd = 12'h000;
    prev_asc = model_ascii(0);
    saw_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done || busy) saw_done++;
    end
    check("midrst_no_done", 32'(saw_done), 32'd0);
    check_reset_outputs("midrst_after");

    // Random conversions with random idle gaps and random ignored starts.
    for (int k = 0; k < 24; k++) begin
      int v, inj, iv, gap;
      v   = int'($urandom_range(0, 255));
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 16)) : 0;
      iv  = int'($urandom_range(0, 255));
      gap = int'($urandom_range(0, 3));
      convert(v, inj, iv, "rand");
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check("rand_idle_done", 32'(done), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
